// File: rtl/axi_write_arbiter.sv
// Two-master AXI3 write-channel arbiter. It grants one master per transaction
// in round-robin order, allows one transaction in flight, counts W beats
// against the granted AWLEN, and sets a sticky flag on a beat-count mismatch.
module axi_write_arbiter #(
    parameter int buswidth = 32,
    parameter int idwidth  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // master 0
    input  logic [idwidth-1:0]    M0_AWID,
    input  logic [31:0]           M0_AWADDR,
    input  logic [3:0]            M0_AWLEN,
    input  logic [2:0]            M0_AWSIZE,
    input  logic [1:0]            M0_AWBURST,
    input  logic                  M0_AWVALID,
    output logic                  M0_AWREADY,
    input  logic [idwidth-1:0]    M0_WID,
    input  logic [buswidth-1:0]   M0_WDATA,
    input  logic [buswidth/8-1:0] M0_WSTRB,
    input  logic                  M0_WLAST,
    input  logic                  M0_WVALID,
    output logic                  M0_WREADY,
    output logic [idwidth-1:0]    M0_BID,
    output logic [1:0]            M0_BRESP,
    output logic                  M0_BVALID,
    input  logic                  M0_BREADY,
    // master 1
    input  logic [idwidth-1:0]    M1_AWID,
    input  logic [31:0]           M1_AWADDR,
    input  logic [3:0]            M1_AWLEN,
    input  logic [2:0]            M1_AWSIZE,
    input  logic [1:0]            M1_AWBURST,
    input  logic                  M1_AWVALID,
    output logic                  M1_AWREADY,
    input  logic [idwidth-1:0]    M1_WID,
    input  logic [buswidth-1:0]   M1_WDATA,
    input  logic [buswidth/8-1:0] M1_WSTRB,
    input  logic                  M1_WLAST,
    input  logic                  M1_WVALID,
    output logic                  M1_WREADY,
    output logic [idwidth-1:0]    M1_BID,
    output logic [1:0]            M1_BRESP,
    output logic                  M1_BVALID,
    input  logic                  M1_BREADY,
    // slave
    output logic [idwidth-1:0]    S_AWID,
    output logic [31:0]           S_AWADDR,
    output logic [3:0]            S_AWLEN,
    output logic [2:0]            S_AWSIZE,
    output logic [1:0]            S_AWBURST,
    output logic                  S_AWVALID,
    input  logic                  S_AWREADY,
    output logic [idwidth-1:0]    S_WID,
    output logic [buswidth-1:0]   S_WDATA,
    output logic [buswidth/8-1:0] S_WSTRB,
    output logic                  S_WLAST,
    output logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic [idwidth-1:0]    S_BID,
    input  logic [1:0]            S_BRESP,
    input  logic                  S_BVALID,
    output logic                  S_BREADY,
    // status
    output logic                  grant,
    output logic                  busy,
    output logic                  proto_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  len_q, len_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic [3:0]  sel_awlen;
    logic        aw_hs, w_hs, b_hs, at_len;

    // Select the granted master's handshake-relevant inputs.
    always_comb begin
        sel_awvalid = grant_q ? M1_AWVALID : M0_AWVALID;
        sel_awlen   = grant_q ? M1_AWLEN   : M0_AWLEN;
        sel_wvalid  = grant_q ? M1_WVALID  : M0_WVALID;
        sel_wlast   = grant_q ? M1_WLAST   : M0_WLAST;
        sel_bready  = grant_q ? M1_BREADY  : M0_BREADY;
        aw_hs       = (state_q == ADDR) && sel_awvalid && S_AWREADY;
        w_hs        = (state_q == DATA) && sel_wvalid && S_WREADY;
        b_hs        = (state_q == RESP) && S_BVALID && sel_bready;
        at_len      = (cnt_q == {1'b0, len_q});
    end

    // State, grant, priority pointer, beat counter and error flag registers.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration in IDLE, beat counting and mismatch detection in DATA.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (M0_AWVALID || M1_AWVALID) begin
                    state_d = ADDR;
                    grant_d = (M0_AWVALID && M1_AWVALID) ? ptr_q : M1_AWVALID;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d   = sel_awlen;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 5'd1;
                    if (sel_wlast) begin
                        if (!at_len) err_d = 1'b1;
                        state_d = RESP;
                    end else if (at_len) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    ptr_d   = ~grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output routing: payloads follow the granted master live, handshakes gated by state.
    always_comb begin
        S_AWID     = grant_q ? M1_AWID    : M0_AWID;
        S_AWADDR   = grant_q ? M1_AWADDR  : M0_AWADDR;
        S_AWLEN    = sel_awlen;
        S_AWSIZE   = grant_q ? M1_AWSIZE  : M0_AWSIZE;
        S_AWBURST  = grant_q ? M1_AWBURST : M0_AWBURST;
        S_AWVALID  = (state_q == ADDR) && sel_awvalid;
        M0_AWREADY = (state_q == ADDR) && !grant_q && S_AWREADY;
        M1_AWREADY = (state_q == ADDR) &&  grant_q && S_AWREADY;

        S_WID      = grant_q ? M1_WID   : M0_WID;
        S_WDATA    = grant_q ? M1_WDATA : M0_WDATA;
        S_WSTRB    = grant_q ? M1_WSTRB : M0_WSTRB;
        // terminate an over-long burst on the beat that reaches AWLEN
        S_WLAST    = sel_wlast || ((state_q == DATA) && at_len);
        S_WVALID   = (state_q == DATA) && sel_wvalid;
        M0_WREADY  = (state_q == DATA) && !grant_q && S_WREADY;
        M1_WREADY  = (state_q == DATA) &&  grant_q && S_WREADY;

        M0_BID     = grant_q ? '0 : S_BID;
        M0_BRESP   = grant_q ? '0 : S_BRESP;
        M1_BID     = grant_q ? S_BID   : '0;
        M1_BRESP   = grant_q ? S_BRESP : '0;
        M0_BVALID  = (state_q == RESP) && !grant_q && S_BVALID;
        M1_BVALID  = (state_q == RESP) &&  grant_q && S_BVALID;
        S_BREADY   = (state_q == RESP) && sel_bready;

        grant      = grant_q;
        busy       = (state_q != IDLE);
        proto_err  = err_q;
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: directed master transactions, a responding
// slave, a transaction-level reference model checked every cycle, and
// literal expectations for the scenarios of interest.
module tb_axi_write_arbiter;

    logic ACLK;
    logic ARESETn;

    logic [1:0][3:0]  awid, wid, bid;
    logic [1:0][31:0] awaddr, wdata;
    logic [1:0][3:0]  awlen, wstrb;
    logic [1:0][2:0]  awsize;
    logic [1:0][1:0]  awburst, bresp;
    logic [1:0]       awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic [3:0]  S_AWID, S_WID, S_BID;
    logic [31:0] S_AWADDR, S_WDATA;
    logic [3:0]  S_AWLEN, S_WSTRB;
    logic [2:0]  S_AWSIZE;
    logic [1:0]  S_AWBURST, S_BRESP;
    logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
    logic        S_BVALID, S_BREADY;
    logic        grant, busy, proto_err;

    int checks = 0;
    int errors = 0;

    axi_write_arbiter #(.buswidth(32), .idwidth(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_AWID(awid[0]), .M0_AWADDR(awaddr[0]), .M0_AWLEN(awlen[0]),
        .M0_AWSIZE(awsize[0]), .M0_AWBURST(awburst[0]), .M0_AWVALID(awvalid[0]),
        .M0_AWREADY(awready[0]), .M0_WID(wid[0]), .M0_WDATA(wdata[0]),
        .M0_WSTRB(wstrb[0]), .M0_WLAST(wlast[0]), .M0_WVALID(wvalid[0]),
        .M0_WREADY(wready[0]), .M0_BID(bid[0]), .M0_BRESP(bresp[0]),
        .M0_BVALID(bvalid[0]), .M0_BREADY(bready[0]),
        .M1_AWID(awid[1]), .M1_AWADDR(awaddr[1]), .M1_AWLEN(awlen[1]),
        .M1_AWSIZE(awsize[1]), .M1_AWBURST(awburst[1]), .M1_AWVALID(awvalid[1]),
        .M1_AWREADY(awready[1]), .M1_WID(wid[1]), .M1_WDATA(wdata[1]),
        .M1_WSTRB(wstrb[1]), .M1_WLAST(wlast[1]), .M1_WVALID(wvalid[1]),
        .M1_WREADY(wready[1]), .M1_BID(bid[1]), .M1_BRESP(bresp[1]),
        .M1_BVALID(bvalid[1]), .M1_BREADY(bready[1]),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
        .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY), .S_WID(S_WID), .S_WDATA(S_WDATA),
        .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .grant(grant), .busy(busy), .proto_err(proto_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=handshake t=%0t", name, $time);
    endtask

    // ---------------- slave responder ----------------
    logic [1:0] slave_resp;
    logic [3:0] slave_id;
    initial begin
        logic hs_aw, hs_wl, hs_b, rst;
        logic [3:0] id;
        S_BVALID = 1'b0; S_BID = '0; S_BRESP = '0; slave_id = '0;
        forever begin
            @(negedge ACLK);
            hs_aw = S_AWVALID && S_AWREADY;
            hs_wl = S_WVALID && S_WREADY && S_WLAST;
            hs_b  = S_BVALID && S_BREADY;
            id    = S_AWID;
            rst   = ARESETn;
            @(posedge ACLK);
            #1;
            if (rst) S_BVALID = 1'b0;
            else begin
                if (hs_aw) slave_id = id;
                if (hs_b) S_BVALID = 1'b0;
                if (hs_wl) begin
                    S_BVALID = 1'b1;
                    S_BID    = slave_id;
                    S_BRESP  = slave_resp;
                end
            end
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    bit m_valid = 0, m_act = 0, m_awd = 0, m_wd = 0, m_err = 0;
    int m_g = 0, m_ptr = 0, m_len = 0, m_beats = 0;
    int gq[$];
    logic wq[$];

    always @(negedge ACLK) begin
        bit in_addr, in_data, in_resp;
        logic [1:0] exp_awr, exp_wr, exp_bv;
        if (m_valid) begin
            in_addr = m_act && !m_awd;
            in_data = m_act && m_awd && !m_wd;
            in_resp = m_act && m_wd;
            exp_awr = '0; exp_wr = '0; exp_bv = '0;
            exp_awr[m_g] = in_addr && S_AWREADY;
            exp_wr[m_g]  = in_data && S_WREADY;
            exp_bv[m_g]  = in_resp && S_BVALID;
            chk("busy", busy, m_act);
            chk("grant", grant, m_g);
            chk("proto_err", proto_err, m_err);
            chk("S_AWVALID", S_AWVALID, in_addr && awvalid[m_g]);
            chk("AWREADY", awready, exp_awr);
            chk("S_AWADDR", S_AWADDR, awaddr[m_g]);
            chk("S_AWLEN", S_AWLEN, awlen[m_g]);
            chk("S_WVALID", S_WVALID, in_data && wvalid[m_g]);
            chk("WREADY", wready, exp_wr);
            chk("S_WDATA", S_WDATA, wdata[m_g]);
            chk("S_WLAST", S_WLAST, wlast[m_g] || (in_data && m_beats == m_len));
            chk("S_BREADY", S_BREADY, in_resp && bready[m_g]);
            chk("BVALID", bvalid, exp_bv);
            if (exp_bv[m_g]) begin
                chk("BID", bid[m_g], S_BID);
                chk("BRESP", bresp[m_g], S_BRESP);
            end
        end
        if (S_AWVALID && S_AWREADY) gq.push_back(int'(grant));
        if (S_WVALID && S_WREADY) wq.push_back(S_WLAST);
        // advance model over the coming rising edge
        if (ARESETn) begin
            m_valid = 1; m_act = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_err = 0;
        end else if (m_valid) begin
            if (!m_act) begin
                if (awvalid != 2'b00) begin
                    m_act = 1; m_awd = 0; m_wd = 0;
                    m_g = (awvalid == 2'b11) ? m_ptr : int'(awvalid[1]);
                end
            end else if (!m_awd) begin
                if (awvalid[m_g] && S_AWREADY) begin
                    m_awd = 1; m_len = int'(awlen[m_g]); m_beats = 0;
                end
            end else if (!m_wd) begin
                if (wvalid[m_g] && S_WREADY) begin
                    if (wlast[m_g] || m_beats == m_len) begin
                        m_wd = 1;
                        if (!(wlast[m_g] && m_beats == m_len)) m_err = 1;
                    end
                    m_beats++;
                end
            end else if (S_BVALID && bready[m_g]) begin
                m_act = 0; m_ptr = 1 - m_g;
            end
        end
    end

    // ---------------- master driver ----------------
    task automatic m_burst(input int m, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats, input int wlast_at, input int abort_after,
                           output logic [1:0] resp);
        int n;
        resp = '0;
        awid[m] = 4'(m + 5); awaddr[m] = addr; awlen[m] = len;
        awsize[m] = 3'd2; awburst[m] = 2'd1; awvalid[m] = 1'b1;
        n = 0;
        forever begin
            @(negedge ACLK);
            if (awready[m]) break;
            n++;
            if (n > 200) begin fail_now("aw_wait"); awvalid[m] = 1'b0; return; end
        end
        @(posedge ACLK); #1;
        awvalid[m] = 1'b0;
        for (int b = 1; b <= nbeats; b++) begin
            wid[m] = 4'(m + 5); wdata[m] = 32'(m * 65536 + b * 17 + int'(len));
            wstrb[m] = '1; wlast[m] = (b == wlast_at); wvalid[m] = 1'b1;
            n = 0;
            forever begin
                @(negedge ACLK);
                if (wready[m]) break;
                n++;
                if (n > 200) begin fail_now("w_wait"); wvalid[m] = 1'b0; return; end
            end
            @(posedge ACLK); #1;
            if (b == abort_after) begin
                wvalid[m] = 1'b0; wlast[m] = 1'b0;
                return;
            end
        end
        wvalid[m] = 1'b0; wlast[m] = 1'b0;
        bready[m] = 1'b1;
        n = 0;
        forever begin
            @(negedge ACLK);
            if (bvalid[m]) break;
            n++;
            if (n > 200) begin fail_now("b_wait"); bready[m] = 1'b0; return; end
        end
        resp = bresp[m];
        @(posedge ACLK); #1;
        bready[m] = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0] r, r0, r1;
        int exp_alt[4];
        exp_alt = '{0, 1, 0, 1};
        awid = '0; wid = '0; awaddr = '0; wdata = '0; awlen = '0; wstrb = '0;
        awsize = '0; awburst = '0; awvalid = '0; wlast = '0; wvalid = '0; bready = '0;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; slave_resp = 2'b00;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b0;

        // reset state
        @(negedge ACLK);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_awvalid", S_AWVALID, 0);
        chk("rst_bready", S_BREADY, 0);
        @(posedge ACLK); #1;

        // single M0 burst, one-cycle arbitration latency
        gq.delete(); wq.delete();
        fork
            m_burst(0, 32'h100, 4'd3, 4, 4, 0, r);
            begin
                @(negedge ACLK); chk("aw_lat_idle", S_AWVALID, 0);
                @(negedge ACLK); chk("aw_lat_addr", S_AWVALID, 1);
                chk("aw_addr_100", S_AWADDR, 32'h100);
            end
        join
        chk("single_bresp", r, 2'b00);
        chk("single_perr", proto_err, 0);
        chk("single_beats", wq.size(), 4);
        chk("single_grant", (gq.size() == 1) ? gq[0] : -1, 0);
        repeat (2) @(posedge ACLK); #1;

        // contention after reset: M0 then M1
        do_reset();
        gq.delete();
        fork
            m_burst(0, 32'h200, 4'd1, 2, 2, 0, r0);
            m_burst(1, 32'h300, 4'd1, 2, 2, 0, r1);
        join
        chk("cont_count", gq.size(), 2);
        for (int i = 0; i < gq.size() && i < 2; i++) chk("cont_order", gq[i], exp_alt[i]);

        // fairness: both request continuously
        gq.delete();
        fork
            begin
                m_burst(0, 32'h1000, 4'd0, 1, 1, 0, r0);
                m_burst(0, 32'h1010, 4'd2, 3, 3, 0, r0);
            end
            begin
                m_burst(1, 32'h2000, 4'd1, 2, 2, 0, r1);
                m_burst(1, 32'h2010, 4'd0, 1, 1, 0, r1);
            end
        join
        chk("fair_count", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("fair_order", gq[i], exp_alt[i]);

        // short burst: AWLEN=3, WLAST on beat 2; error remains across a clean burst
        slave_resp = 2'b10;
        m_burst(0, 32'h400, 4'd3, 2, 2, 0, r);
        chk("short_bresp", r, 2'b10);
        chk("short_perr", proto_err, 1);
        slave_resp = 2'b00;
        m_burst(1, 32'h500, 4'd0, 1, 1, 0, r);
        chk("sticky_bresp", r, 2'b00);
        chk("sticky_perr", proto_err, 1);

        // long burst: AWLEN=1, WLAST low on beat 2 gets forced
        do_reset();
        chk("long_pre_perr", proto_err, 0);
        wq.delete();
        m_burst(1, 32'h600, 4'd1, 2, 0, 0, r);
        chk("long_beats", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("long_wlast_b1", wq[0], 0);
            chk("long_wlast_b2", wq[1], 1);
        end
        chk("long_perr", proto_err, 1);

        // reset in the middle of DATA after 2 beats
        do_reset();
        m_burst(0, 32'h700, 4'd3, 4, 4, 2, r);
        @(negedge ACLK); chk("mid_busy_pre", busy, 1);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("mid_busy", busy, 0);
        chk("mid_grant", grant, 0);
        chk("mid_wready", wready, 2'b00);
        chk("mid_bvalid", bvalid, 2'b00);
        chk("mid_swvalid", S_WVALID, 0);
        @(posedge ACLK); #1;
        gq.delete();
        m_burst(1, 32'h800, 4'd0, 1, 1, 0, r);
        chk("post_bresp", r, 2'b00);
        chk("post_grant", (gq.size() == 1) ? gq[0] : -1, 1);

        repeat (3) @(posedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
